rf68000_ring_hub: RTL and testbench

Ring root stage for the rf68000 NIC rings. It sits between the last NIC's `packet_o`/`rpacket_o`/`ipacket_o` and the first NIC's inputs, and closes all three rings. On every pass it ages each live packet and removes packets that have circled too long. For each expired unicast request it returns a `PT_ERR` response to the sender, so the sender's slave cycle terminates instead of hanging.

---
 rtl/nic_pkg.sv | 50 +++++
 rtl/rf68000_ring_err_fifo.sv | 47 ++++
 rtl/rf68000_ring_hub.sv | 127 ++++++++++++
 tb/tb_rf68000_ring_hub.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/nic_pkg.sv
// Shared NIC ring types: packet formats, packet type codes, ring ids and ageing limits.
package nic_pkg;

  typedef enum logic [3:0] {
    PT_NULL  = 4'd0,
    PT_READ  = 4'd1,
    PT_AREAD = 4'd2,
    PT_WRITE = 4'd3,
    PT_ACK   = 4'd4,
    PT_ERR   = 4'd5,
    PT_IRQ   = 4'd6
  } pkt_type_e;

  localparam logic [5:0] ID_NONE      = 6'd0;
  localparam logic [5:0] ID_BCAST     = 6'd63;
  localparam logic [5:0] ID_HUB       = 6'd61;
  localparam logic [5:0] RING_MAX_AGE = 6'd31;

  typedef struct packed {
    logic [5:0]  sid;
    logic [5:0]  did;
    logic [5:0]  age;
    pkt_type_e   typ;
    logic        ack;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat;
  } packet_t;

  typedef struct packed {
    logic [5:0] sid;
    logic [5:0] did;
    logic [5:0] age;
    logic [2:0] ipl;
    logic [7:0] vec;
  } ipacket_t;

  // One pending error response: who to answer and which address failed.
  typedef struct packed {
    logic [5:0]  sid;
    logic [31:0] adr;
  } err_rec_t;

  // A request whose sender is blocked waiting for a reply.
  function automatic logic needs_err_rsp(packet_t p);
    return (p.typ == PT_READ || p.typ == PT_AREAD || p.typ == PT_WRITE) &&
           (p.did != ID_BCAST);
  endfunction

endpackage

// File: rtl/rf68000_ring_err_fifo.sv
// Pending-error FIFO: registered write, combinational head from the read pointer.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module rf68000_ring_err_fifo
  import nic_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk_i,
  input  logic     rst_i,
  input  logic     push_i,
  input  logic     pop_i,
  input  err_rec_t din_i,
  output logic     full_o,
  output logic     empty_o,
  output err_rec_t head_o
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wp_q, wp_d, rp_q, rp_d;
  err_rec_t    mem_q [DEPTH];
  logic        wr, rd;

  assign empty_o = (wp_q == rp_q);
  assign full_o  = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
  assign head_o  = mem_q[rp_q[AW-1:0]];
  assign wr      = push_i && (!full_o || pop_i);
  assign rd      = pop_i && !empty_o;
  assign wp_d    = wp_q + (AW+1)'(wr);
  assign rp_d    = rp_q + (AW+1)'(rd);

  // Pointer registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
    end
  end

  // Storage; contents need no reset since empty_o guards the head.
  always_ff @(posedge clk_i) begin
    if (wr) mem_q[wp_q[AW-1:0]] <= din_i;
  end

endmodule

// File: rtl/rf68000_ring_hub.sv
// Ring root: ages packets on all three rings, removes expired ones and returns
// PT_ERR responses for expired unicast requests so the sender is not left hanging.
module rf68000_ring_hub
  import nic_pkg::*;
#(
  parameter logic [5:0] HUB_ID    = ID_HUB,
  parameter logic [5:0] MAX_AGE   = RING_MAX_AGE,
  parameter int         ERR_DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  packet_t     packet_i,
  output packet_t     packet_o,
  input  packet_t     rpacket_i,
  output packet_t     rpacket_o,
  input  ipacket_t    ipacket_i,
  output ipacket_t    ipacket_o,
  output logic [15:0] req_drop_cnt_o,
  output logic [15:0] rsp_drop_cnt_o,
  output logic [15:0] irq_drop_cnt_o,
  output logic        err_ovf_o
);

  packet_t     pkt_d, pkt_q, rpkt_d, rpkt_q;
  ipacket_t    ipkt_d, ipkt_q;
  logic [15:0] req_cnt_q, rsp_cnt_q, irq_cnt_q;
  logic        ovf_q, ovf_d;
  logic        req_exp, rsp_exp, irq_exp;
  logic        err_push, err_pop, fifo_full, fifo_empty;
  err_rec_t    err_din, err_head;

  assign err_din = '{sid: packet_i.sid, adr: packet_i.adr};

  rf68000_ring_err_fifo #(.DEPTH(ERR_DEPTH)) u_err_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (err_push),
    .pop_i   (err_pop),
    .din_i   (err_din),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (err_head)
  );

  // Request and interrupt rings: age live packets, zero expired ones.
  always_comb begin
    pkt_d    = packet_i;
    req_exp  = 1'b0;
    err_push = 1'b0;
    if (packet_i.did != ID_NONE) begin
      if (packet_i.age >= MAX_AGE) begin
        pkt_d    = '0;
        req_exp  = 1'b1;
        err_push = needs_err_rsp(packet_i);
      end else begin
        pkt_d.age = packet_i.age + 6'd1;
      end
    end
    ipkt_d  = ipacket_i;
    irq_exp = 1'b0;
    if (ipacket_i.did != ID_NONE) begin
      if (ipacket_i.age >= MAX_AGE) begin
        ipkt_d  = '0;
        irq_exp = 1'b1;
      end else begin
        ipkt_d.age = ipacket_i.age + 6'd1;
      end
    end
  end

  // Response ring: age first, then fill a free slot (incl. one just freed) with an ERR.
  always_comb begin
    rpkt_d  = rpacket_i;
    rsp_exp = 1'b0;
    err_pop = 1'b0;
    if (rpacket_i.did != ID_NONE) begin
      if (rpacket_i.age >= MAX_AGE) begin
        rpkt_d  = '0;
        rsp_exp = 1'b1;
      end else begin
        rpkt_d.age = rpacket_i.age + 6'd1;
      end
    end
    if (rpkt_d.did == ID_NONE && !fifo_empty) begin
      err_pop    = 1'b1;
      rpkt_d     = '0;
      rpkt_d.sid = HUB_ID;
      rpkt_d.did = err_head.sid;
      rpkt_d.typ = PT_ERR;
      rpkt_d.ack = 1'b1;
      rpkt_d.adr = err_head.adr;
    end
  end

  // A record is lost only when full and nothing drains this cycle.
  assign ovf_d = ovf_q | (err_push & fifo_full & ~err_pop);

  // Ring stages, drop counters and sticky overflow flag.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pkt_q     <= '0;
      rpkt_q    <= '0;
      ipkt_q    <= '0;
      req_cnt_q <= '0;
      rsp_cnt_q <= '0;
      irq_cnt_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      pkt_q     <= pkt_d;
      rpkt_q    <= rpkt_d;
      ipkt_q    <= ipkt_d;
      req_cnt_q <= req_cnt_q + 16'(req_exp);
      rsp_cnt_q <= rsp_cnt_q + 16'(rsp_exp);
      irq_cnt_q <= irq_cnt_q + 16'(irq_exp);
      ovf_q     <= ovf_d;
    end
  end

  assign packet_o       = pkt_q;
  assign rpacket_o      = rpkt_q;
  assign ipacket_o      = ipkt_q;
  assign req_drop_cnt_o = req_cnt_q;
  assign rsp_drop_cnt_o = rsp_cnt_q;
  assign irq_drop_cnt_o = irq_cnt_q;
  assign err_ovf_o      = ovf_q;

endmodule

// File: tb/tb_rf68000_ring_hub.sv
// Directed bench for rf68000_ring_hub: expected ring outputs queued with each stimulus step.
module tb_rf68000_ring_hub;
  import nic_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i;
  packet_t     packet_i, packet_o, rpacket_i, rpacket_o;
  ipacket_t    ipacket_i, ipacket_o;
  logic [15:0] req_drop_cnt_o, rsp_drop_cnt_o, irq_drop_cnt_o;
  logic        err_ovf_o;

  int total = 0;
  int fails = 0;

  typedef struct {
    string    tag;
    packet_t  p;
    packet_t  r;
    ipacket_t i;
  } exp_t;
  exp_t sb[$];

  localparam packet_t  PZ = '0;
  localparam ipacket_t IZ = '0;

  always #5 clk_i = ~clk_i;

  rf68000_ring_hub dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .packet_i       (packet_i),
    .packet_o       (packet_o),
    .rpacket_i      (rpacket_i),
    .rpacket_o      (rpacket_o),
    .ipacket_i      (ipacket_i),
    .ipacket_o      (ipacket_o),
    .req_drop_cnt_o (req_drop_cnt_o),
    .rsp_drop_cnt_o (rsp_drop_cnt_o),
    .irq_drop_cnt_o (irq_drop_cnt_o),
    .err_ovf_o      (err_ovf_o)
  );

  function automatic packet_t pk(logic [5:0] sid, logic [5:0] did, logic [5:0] age,
                                 pkt_type_e typ, logic ack, logic [31:0] adr, logic [31:0] dat);
    packet_t p;
    p = '0;
    p.sid = sid; p.did = did; p.age = age; p.typ = typ;
    p.ack = ack; p.adr = adr; p.dat = dat;
    return p;
  endfunction

  function automatic packet_t errp(logic [5:0] did, logic [31:0] adr);
    return pk(6'd61, did, 6'd0, PT_ERR, 1'b1, adr, 32'd0);
  endfunction

  function automatic ipacket_t ip(logic [5:0] sid, logic [5:0] did, logic [5:0] age, logic [2:0] ipl);
    ipacket_t p;
    p = '0;
    p.sid = sid; p.did = did; p.age = age; p.ipl = ipl; p.vec = 8'h40;
    return p;
  endfunction

  task automatic chk_pkt(input string tag, input packet_t obs, input packet_t exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_ipkt(input string tag, input ipacket_t obs, input ipacket_t exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_cnt(input string tag, input int req, input int rsp, input int irq);
    chk_val({tag, ".req_cnt"}, req_drop_cnt_o, 16'(req));
    chk_val({tag, ".rsp_cnt"}, rsp_drop_cnt_o, 16'(rsp));
    chk_val({tag, ".irq_cnt"}, irq_drop_cnt_o, 16'(irq));
  endtask

  // Drive one cycle of inputs, queue what must leave the hub one clock later, then check it.
  task automatic step(input string tag, input packet_t p, input packet_t r, input ipacket_t i,
                      input packet_t ep, input packet_t er, input ipacket_t ei);
    exp_t e;
    packet_i  = p;
    rpacket_i = r;
    ipacket_i = i;
    e.tag = tag; e.p = ep; e.r = er; e.i = ei;
    sb.push_back(e);
    @(posedge clk_i);
    #1;
    e = sb.pop_front();
    chk_pkt({e.tag, ".packet_o"}, packet_o, e.p);
    chk_pkt({e.tag, ".rpacket_o"}, rpacket_o, e.r);
    chk_ipkt({e.tag, ".ipacket_o"}, ipacket_o, e.i);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    packet_t   rbusy, rbusy_o, rq;
    pkt_type_e t;
    rst_i     = 1'b1;
    packet_i  = PZ;
    rpacket_i = PZ;
    ipacket_i = IZ;
    repeat (2) @(posedge clk_i);
    #1;
    chk_pkt("reset.packet_o", packet_o, PZ);
    chk_pkt("reset.rpacket_o", rpacket_o, PZ);
    chk_ipkt("reset.ipacket_o", ipacket_o, IZ);
    chk_cnt("reset", 0, 0, 0);
    chk_val("reset.ovf", 16'(err_ovf_o), 16'd0);
    rst_i = 1'b0;

    // Live packets age by one on every ring.
    step("live", pk(3, 5, 4, PT_READ, 0, 32'h0000_1000, 32'd0),
         pk(2, 7, 2, PT_ACK, 1, 32'h0000_2000, 32'hdead_beef), ip(4, 1, 10, 3'd3),
         pk(3, 5, 5, PT_READ, 0, 32'h0000_1000, 32'd0),
         pk(2, 7, 3, PT_ACK, 1, 32'h0000_2000, 32'hdead_beef), ip(4, 1, 11, 3'd3));
    chk_cnt("live", 0, 0, 0);

    // Empty slots keep their age; age just below the limit still forwards.
    step("empty", pk(4, 0, 7, PT_NULL, 0, 32'd0, 32'd0), pk(0, 0, 9, PT_NULL, 0, 32'd0, 32'd0),
         ip(1, 2, 30, 3'd5),
         pk(4, 0, 7, PT_NULL, 0, 32'd0, 32'd0), pk(0, 0, 9, PT_NULL, 0, 32'd0, 32'd0),
         ip(1, 2, 31, 3'd5));

    // Expired unicast read: dropped now, ERR response one cycle later.
    step("rd_exp", pk(3, 9, 31, PT_READ, 0, 32'h4000_0010, 32'd0), PZ, IZ, PZ, PZ, IZ);
    chk_cnt("rd_exp", 1, 0, 0);
    step("rd_err", PZ, PZ, IZ, PZ, errp(3, 32'h4000_0010), IZ);

    // Broadcast: forwarded at 30, silently removed at 31; interrupt expiry alongside.
    step("bc_fwd", pk(2, 63, 30, PT_WRITE, 0, 32'h0000_0100, 32'h1234_5678), PZ, IZ,
         pk(2, 63, 31, PT_WRITE, 0, 32'h0000_0100, 32'h1234_5678), PZ, IZ);
    step("bc_drop", pk(2, 63, 31, PT_WRITE, 0, 32'h0000_0100, 32'h1234_5678), PZ, ip(3, 4, 31, 3'd2),
         PZ, PZ, IZ);
    chk_cnt("bc_drop", 2, 0, 1);
    // No ERR for the broadcast; hub-addressed packet still forwards; age above limit drops.
    step("bc_noerr", pk(1, 61, 5, PT_WRITE, 0, 32'h0000_0200, 32'd7), PZ, ip(3, 4, 45, 3'd1),
         pk(1, 61, 6, PT_WRITE, 0, 32'h0000_0200, 32'd7), PZ, IZ);
    chk_cnt("bc_noerr", 2, 0, 2);

    // Expired non-request type on the request ring: counted, no ERR.
    step("ack_exp", pk(2, 8, 31, PT_ACK, 1, 32'h0000_0300, 32'd0), PZ, IZ, PZ, PZ, IZ);
    step("ack_noerr", PZ, PZ, IZ, PZ, PZ, IZ);
    chk_cnt("ack_exp", 3, 0, 2);

    // Five expired requests while the response ring is busy: four queue, fifth overflows.
    rbusy   = pk(5, 6, 1, PT_ACK, 1, 32'h0000_0400, 32'd0);
    rbusy_o = pk(5, 6, 2, PT_ACK, 1, 32'h0000_0400, 32'd0);
    for (int k = 0; k < 5; k++) begin
      t  = (k % 3 == 0) ? PT_READ : ((k % 3 == 1) ? PT_AREAD : PT_WRITE);
      rq = pk(6'(k + 1), 9, 31, t, 0, 32'h1000_0000 + 32'(k * 4), 32'd0);
      step($sformatf("ovf_fill%0d", k), rq, rbusy, IZ, PZ, rbusy_o, IZ);
    end
    chk_val("ovf_fill.ovf", 16'(err_ovf_o), 16'd1);
    chk_cnt("ovf_fill", 8, 0, 2);
    for (int k = 0; k < 4; k++)
      step($sformatf("ovf_drain%0d", k), PZ, PZ, IZ, PZ,
           errp(6'(k + 1), 32'h1000_0000 + 32'(k * 4)), IZ);
    step("ovf_done", PZ, PZ, IZ, PZ, PZ, IZ);

    // Response expiry frees the slot that carries the queued ERR in the same cycle.
    step("rsp_pre", pk(6, 9, 31, PT_READ, 0, 32'h2000_0040, 32'd0), PZ, IZ, PZ, PZ, IZ);
    step("rsp_exp", PZ, pk(9, 6, 31, PT_ACK, 1, 32'h0000_0500, 32'd0), IZ,
         PZ, errp(6, 32'h2000_0040), IZ);
    chk_cnt("rsp_exp", 9, 1, 2);
    chk_val("rsp_exp.ovf", 16'(err_ovf_o), 16'd1);

    // Reset with two records pending discards them.
    step("rst_a", pk(7, 9, 31, PT_READ, 0, 32'h3000_0000, 32'd0), rbusy, IZ, PZ, rbusy_o, IZ);
    step("rst_b", pk(8, 9, 31, PT_WRITE, 0, 32'h3000_0004, 32'd0), rbusy, IZ, PZ, rbusy_o, IZ);
    chk_cnt("rst_b", 11, 1, 2);
    rst_i = 1'b1;
    step("rst", PZ, PZ, IZ, PZ, PZ, IZ);
    chk_cnt("rst", 0, 0, 0);
    chk_val("rst.ovf", 16'(err_ovf_o), 16'd0);
    rst_i = 1'b0;
    for (int k = 0; k < 3; k++)
      step($sformatf("post_rst%0d", k), PZ, PZ, IZ, PZ, PZ, IZ);
    chk_cnt("post_rst", 0, 0, 0);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
